max7219_rx: RTL and testbench

Receiving end of the MAX7219 serial link: a clocked frame receiver plus register-file model of a chain of `SIZE` cascaded MAX7219 devices. It samples `mosi` under `cs` framing on the system clock and captures exactly `16*SIZE` bits per frame. On `cs` rising it commits one 16-bit address/data word per device into that device's registers. It is the checker/loopback target for the matrix driver path and exports the decoded display image for on-board emulation and for scoreboarding in simulation.

---
 rtl/max7219_rx.sv | 172 +++++++++++++++++
 tb/tb_max7219_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_rx.sv
// Frame receiver and register-file model for a chain of SIZE cascaded MAX7219 devices.
// Captures 16*SIZE bits per cs-low frame and commits one address/data word per device on cs rising.
module max7219_rx #(
  parameter int SIZE = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mosi,
  input  logic                cs,
  output logic                frame_valid,
  output logic                frame_error,
  output logic [8*SIZE-1:0]   rx_address,
  output logic [8*SIZE-1:0]   rx_data,
  output logic [64*SIZE-1:0]  display,
  output logic [8*SIZE-1:0]   decode_mode,
  output logic [4*SIZE-1:0]   intensity,
  output logic [3*SIZE-1:0]   scan_limit,
  output logic [SIZE-1:0]     normal_op,
  output logic [SIZE-1:0]     display_test
);

  localparam int NBITS = 16 * SIZE;
  localparam int CW    = $clog2(NBITS + 2);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [NBITS-1:0]     shift_q, shift_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 frame_error_q, frame_error_d;
  logic [8*SIZE-1:0]    rx_address_q, rx_address_d;
  logic [8*SIZE-1:0]    rx_data_q, rx_data_d;
  logic [64*SIZE-1:0]   display_q, display_d;
  logic [8*SIZE-1:0]    decode_mode_q, decode_mode_d;
  logic [4*SIZE-1:0]    intensity_q, intensity_d;
  logic [3*SIZE-1:0]    scan_limit_q, scan_limit_d;
  logic [SIZE-1:0]      normal_op_q, normal_op_d;
  logic [SIZE-1:0]      display_test_q, display_test_d;

  always_comb begin : p_next
    logic       commit;
    logic [7:0] addr;
    logic [7:0] data;
    state_d        = state_q;
    shift_d        = shift_q;
    count_d        = count_q;
    frame_valid_d  = 1'b0;
    frame_error_d  = 1'b0;
    rx_address_d   = rx_address_q;
    rx_data_d      = rx_data_q;
    display_d      = display_q;
    decode_mode_d  = decode_mode_q;
    intensity_d    = intensity_q;
    scan_limit_d   = scan_limit_q;
    normal_op_d    = normal_op_q;
    display_test_d = display_test_q;
    commit         = 1'b0;
    addr           = 8'h00;
    data           = 8'h00;

    case (state_q)
      IDLE: begin
        if (!cs) begin
          shift_d = {shift_q[NBITS-2:0], mosi};
          count_d = CW'(1);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (!cs) begin
          shift_d = {shift_q[NBITS-2:0], mosi};
          // Saturating one past a full frame is enough to flag an overlong frame.
          if (count_q != CW'(NBITS + 1)) begin
            count_d = count_q + CW'(1);
          end else begin
            count_d = count_q;
          end
        end else begin
          state_d = IDLE;
          count_d = '0;
          if (count_q == CW'(NBITS)) begin
            commit        = 1'b1;
            frame_valid_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    if (commit) begin
      rx_address_d = '0;
      rx_data_d    = '0;
      for (int k = 0; k < SIZE; k++) begin
        addr = shift_q[16*k+15 -: 8];
        data = shift_q[16*k+7 -: 8];
        rx_address_d[8*k+7 -: 8] = addr;
        rx_data_d[8*k+7 -: 8]    = data;
        for (int d = 0; d < 8; d++) begin
          if (addr[3:0] == 4'(d + 1)) begin
            display_d[64*k+8*d +: 8] = data;
          end else begin
            display_d[64*k+8*d +: 8] = display_d[64*k+8*d +: 8];
          end
        end
        // Digit and no-op addresses fall to the default arm.
        case (addr[3:0])
          4'h9:    decode_mode_d[8*k +: 8]  = data;
          4'hA:    intensity_d[4*k +: 4]    = data[3:0];
          4'hB:    scan_limit_d[3*k +: 3]   = data[2:0];
          4'hC:    normal_op_d[k]           = data[0];
          4'hF:    display_test_d[k]        = data[0];
          default: ;
        endcase
      end
    end else begin
      commit = 1'b0;
    end
  end

  // State, shift register and register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      count_q        <= '0;
      frame_valid_q  <= 1'b0;
      frame_error_q  <= 1'b0;
      rx_address_q   <= '0;
      rx_data_q      <= '0;
      display_q      <= '0;
      decode_mode_q  <= '0;
      intensity_q    <= '0;
      scan_limit_q   <= '0;
      normal_op_q    <= '0;
      display_test_q <= '0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      count_q        <= count_d;
      frame_valid_q  <= frame_valid_d;
      frame_error_q  <= frame_error_d;
      rx_address_q   <= rx_address_d;
      rx_data_q      <= rx_data_d;
      display_q      <= display_d;
      decode_mode_q  <= decode_mode_d;
      intensity_q    <= intensity_d;
      scan_limit_q   <= scan_limit_d;
      normal_op_q    <= normal_op_d;
      display_test_q <= display_test_d;
    end
  end

  assign frame_valid  = frame_valid_q;
  assign frame_error  = frame_error_q;
  assign rx_address   = rx_address_q;
  assign rx_data      = rx_data_q;
  assign display      = display_q;
  assign decode_mode  = decode_mode_q;
  assign intensity    = intensity_q;
  assign scan_limit   = scan_limit_q;
  assign normal_op    = normal_op_q;
  assign display_test = display_test_q;

endmodule

// File: tb/tb_max7219_rx.sv
// Testbench for max7219_rx (SIZE=2): vector table, hand-written corner sequences and
// randomized frames checked against a per-device register model.
module tb_max7219_rx;
  localparam int SIZE = 2;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                mosi;
  logic                cs;
  logic                frame_valid;
  logic                frame_error;
  logic [8*SIZE-1:0]   rx_address;
  logic [8*SIZE-1:0]   rx_data;
  logic [64*SIZE-1:0]  display;
  logic [8*SIZE-1:0]   decode_mode;
  logic [4*SIZE-1:0]   intensity;
  logic [3*SIZE-1:0]   scan_limit;
  logic [SIZE-1:0]     normal_op;
  logic [SIZE-1:0]     display_test;

  always #5 clk = ~clk;

  max7219_rx #(.SIZE(SIZE)) dut (
    .clk(clk), .reset_n(reset_n), .mosi(mosi), .cs(cs),
    .frame_valid(frame_valid), .frame_error(frame_error),
    .rx_address(rx_address), .rx_data(rx_data), .display(display),
    .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
    .normal_op(normal_op), .display_test(display_test)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Pulse monitor: counts pulses and measures spacing between frame_valid pulses.
  int cyc = 0, valid_cnt = 0, err_cnt = 0, last_v = -1, last_gap = 0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (frame_valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      if (last_v >= 0) last_gap = cyc - last_v;
      last_v = cyc;
    end
    if (frame_error === 1'b1) err_cnt = err_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Reference model: plain per-device register arrays.
  logic [7:0] m_dig  [SIZE][8];
  logic [7:0] m_dec  [SIZE];
  logic [3:0] m_int  [SIZE];
  logic [2:0] m_scan [SIZE];
  logic       m_nop  [SIZE];
  logic       m_dt   [SIZE];
  logic [7:0] m_addr [SIZE];
  logic [7:0] m_data [SIZE];

  task automatic model_reset();
    for (int k = 0; k < SIZE; k++) begin
      for (int d = 0; d < 8; d++) m_dig[k][d] = 8'h00;
      m_dec[k] = 8'h00; m_int[k] = 4'h0; m_scan[k] = 3'h0;
      m_nop[k] = 1'b0;  m_dt[k] = 1'b0;  m_addr[k] = 8'h00; m_data[k] = 8'h00;
    end
  endtask

  // val holds the frame with the first-sent bit at position nbits-1.
  task automatic model_frame(input int nbits, input logic [47:0] val);
    logic [15:0] w;
    int dev;
    int r;
    if (nbits == 16*SIZE) begin
      for (int j = 0; j < SIZE; j++) begin
        w   = val[16*(SIZE-1-j) +: 16];
        dev = SIZE - 1 - j;  // first word sent travels furthest down the chain
        m_addr[dev] = w[15:8];
        m_data[dev] = w[7:0];
        r = int'(w[11:8]);
        if (r >= 1 && r <= 8) m_dig[dev][r-1] = w[7:0];
        else if (r == 9)  m_dec[dev]  = w[7:0];
        else if (r == 10) m_int[dev]  = w[3:0];
        else if (r == 11) m_scan[dev] = w[2:0];
        else if (r == 12) m_nop[dev]  = w[0];
        else if (r == 15) m_dt[dev]   = w[0];
      end
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total = n_total + 1;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass = n_pass + 1;
  endtask

  task automatic check_model(input string tag);
    logic [127:0] e_disp, e_dec, e_int, e_scan, e_nop, e_dt, e_addr, e_data;
    e_disp = '0; e_dec = '0; e_int = '0; e_scan = '0; e_nop = '0; e_dt = '0; e_addr = '0; e_data = '0;
    for (int k = 0; k < SIZE; k++) begin
      for (int d = 0; d < 8; d++) e_disp[64*k+8*d +: 8] = m_dig[k][d];
      e_dec[8*k +: 8] = m_dec[k];   e_int[4*k +: 4] = m_int[k];
      e_scan[3*k +: 3] = m_scan[k]; e_nop[k] = m_nop[k]; e_dt[k] = m_dt[k];
      e_addr[8*k +: 8] = m_addr[k]; e_data[8*k +: 8] = m_data[k];
    end
    chk({tag, " display"}, 128'(display), e_disp);
    chk({tag, " decode_mode"}, 128'(decode_mode), e_dec);
    chk({tag, " intensity"}, 128'(intensity), e_int);
    chk({tag, " scan_limit"}, 128'(scan_limit), e_scan);
    chk({tag, " normal_op"}, 128'(normal_op), e_nop);
    chk({tag, " display_test"}, 128'(display_test), e_dt);
    chk({tag, " rx_address"}, 128'(rx_address), e_addr);
    chk({tag, " rx_data"}, 128'(rx_data), e_data);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Sends nbits with cs low, then raises cs and returns just after the edge that samples it.
  task automatic send_bits(input int nbits, input logic [47:0] val);
    for (int i = nbits - 1; i >= 0; i--) begin
      cs = 1'b0; mosi = val[i]; step();
    end
    cs = 1'b1; mosi = 1'($urandom); step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cs = 1'b1; mosi = 1'($urandom); step();
    end
  endtask

  typedef struct {
    int          nbits;
    logic [47:0] bits;
    int          gap;
    logic        exp_valid;
    logic        exp_error;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
    logic [1:0]  exp_nop;
    logic [7:0]  exp_int;
    logic [7:0]  exp_dig;  // display[23:16]
  } vec_t;

  vec_t tbl [5];
  int v0, e0, nb, exp_ok;
  logic [47:0] val;
  logic [15:0] w0, w1;

  initial begin
    tbl[0] = '{32, 48'h0000_0C01_0A07, 2, 1'b1, 1'b0, 16'h0C0A, 16'h0107, 2'b10, 8'h07, 8'h00};
    tbl[1] = '{32, 48'h0000_0000_03A5, 1, 1'b1, 1'b0, 16'h0003, 16'h00A5, 2'b10, 8'h07, 8'hA5};
    tbl[2] = '{32, 48'h0000_0000_F35A, 2, 1'b1, 1'b0, 16'h00F3, 16'h005A, 2'b10, 8'h07, 8'h5A};
    tbl[3] = '{31, 48'h0000_0C00_0A00, 2, 1'b0, 1'b1, 16'h00F3, 16'h005A, 2'b10, 8'h07, 8'h5A};
    tbl[4] = '{33, 48'h0001_0C00_0A00, 2, 1'b0, 1'b1, 16'h00F3, 16'h005A, 2'b10, 8'h07, 8'h5A};

    reset_n = 1'b0; cs = 1'b1; mosi = 1'b0;
    model_reset();
    repeat (3) step();
    check_model("reset");
    chk("reset frame_valid", 128'(frame_valid), 128'(0));
    chk("reset frame_error", 128'(frame_error), 128'(0));
    reset_n = 1'b1;
    v0 = valid_cnt; e0 = err_cnt;
    repeat (20) step();
    chk("post-reset valid pulses", 128'(valid_cnt - v0), 128'(0));
    chk("post-reset error pulses", 128'(err_cnt - e0), 128'(0));

    for (int i = 0; i < 5; i++) begin
      v0 = valid_cnt; e0 = err_cnt;
      send_bits(tbl[i].nbits, tbl[i].bits);
      model_frame(tbl[i].nbits, tbl[i].bits);
      chk($sformatf("vec%0d frame_valid", i), 128'(frame_valid), 128'(tbl[i].exp_valid));
      chk($sformatf("vec%0d frame_error", i), 128'(frame_error), 128'(tbl[i].exp_error));
      chk($sformatf("vec%0d rx_address", i), 128'(rx_address), 128'(tbl[i].exp_addr));
      chk($sformatf("vec%0d rx_data", i), 128'(rx_data), 128'(tbl[i].exp_data));
      chk($sformatf("vec%0d normal_op", i), 128'(normal_op), 128'(tbl[i].exp_nop));
      chk($sformatf("vec%0d intensity", i), 128'(intensity), 128'(tbl[i].exp_int));
      chk($sformatf("vec%0d digit2", i), 128'(display[23:16]), 128'(tbl[i].exp_dig));
      chk($sformatf("vec%0d valid count", i), 128'(valid_cnt - v0), 128'(tbl[i].exp_valid));
      chk($sformatf("vec%0d error count", i), 128'(err_cnt - e0), 128'(tbl[i].exp_error));
      check_model($sformatf("vec%0d", i));
      idle(tbl[i].gap - 1);
    end
    step();
    chk("valid is one cycle", 128'(frame_valid), 128'(0));

    // Loopback cadence: 32 low cycles then 2 high cycles.
    e0 = err_cnt;
    for (int f = 0; f < 5; f++) begin
      send_bits(32, 48'h0000_0B07_09FF);
      model_frame(32, 48'h0000_0B07_09FF);
      if (f > 0) chk($sformatf("loopback spacing %0d", f), 128'(last_gap), 128'(34));
      idle(1);
    end
    chk("loopback scan_limit dev1", 128'(scan_limit[5:3]), 128'(3'd7));
    chk("loopback decode_mode dev0", 128'(decode_mode[7:0]), 128'(8'hFF));
    chk("loopback errors", 128'(err_cnt - e0), 128'(0));
    check_model("loopback");

    // Reset after 10 bits of a frame.
    for (int i = 0; i < 10; i++) begin
      cs = 1'b0; mosi = 1'($urandom); step();
    end
    reset_n = 1'b0; cs = 1'b1;
    step(); step();
    model_reset();
    check_model("midreset");
    reset_n = 1'b1;
    v0 = valid_cnt; e0 = err_cnt;
    repeat (5) step();
    chk("midreset valid pulses", 128'(valid_cnt - v0), 128'(0));
    chk("midreset error pulses", 128'(err_cnt - e0), 128'(0));
    v0 = valid_cnt;
    send_bits(32, 48'h0000_0C01_0A07);
    model_frame(32, 48'h0000_0C01_0A07);
    chk("after midreset valid", 128'(valid_cnt - v0), 128'(1));
    check_model("after midreset");
    idle(1);

    // Randomized frames, mostly well-formed, some with bad lengths.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 9) < 7) begin
        nb = 32;
        w0 = {($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom), 8'($urandom)};
        w1 = {($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom), 8'($urandom)};
        val = {16'h0000, w0, w1};
      end else begin
        nb = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 1) == 1) ? 31 : 33) : int'($urandom_range(1, 40));
        val = {16'($urandom), 32'($urandom)};
      end
      exp_ok = (nb == 32) ? 1 : 0;
      v0 = valid_cnt; e0 = err_cnt;
      send_bits(nb, val);
      model_frame(nb, val);
      chk($sformatf("rand%0d valid count", t), 128'(valid_cnt - v0), 128'(exp_ok));
      chk($sformatf("rand%0d error count", t), 128'(err_cnt - e0), 128'(1 - exp_ok));
      check_model($sformatf("rand%0d", t));
      idle(int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
